// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared ADC constants and averaging FSM state encoding
package adc_pkg;

  localparam int ADC_BITS = 12;
  localparam int SEQ_BITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACUM = 2'd1,
    PEND = 2'd2
  } estado_t;

endpackage

// File: rtl/contador_sat.sv
// rtl/contador_sat.sv - saturating up-counter
module contador_sat #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/adc_promedio_fifo.sv
// rtl/adc_promedio_fifo.sv - averages 2^LOG2_PROM XADC samples and pushes {seq, mean} into a FIFO
module adc_promedio_fifo
  import adc_pkg::*;
#(
  parameter int LOG2_PROM = 2
) (
  input  logic        clk_78MHz_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [15:0] data_i,
  input  logic        ready_i,
  input  logic        fifo_full_i,
  output logic        fifo_wr_en_o,
  output logic [15:0] fifo_din_o,
  output logic [7:0]  overflow_cnt_o,
  output logic        busy_o
);

  localparam int ACC_W = ADC_BITS + LOG2_PROM;
  localparam int CNT_W = (LOG2_PROM == 0) ? 1 : LOG2_PROM;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << LOG2_PROM) - 1);

  estado_t              state;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     sum;
  logic [CNT_W-1:0]     cnt;
  logic [SEQ_BITS-1:0]  seq;
  logic [ADC_BITS-1:0]  mean_new;
  logic                 take;
  logic                 done;
  logic                 wr;
  logic                 drop;
  logic                 unused_status_bits;

  // The low nibble of the DRP word carries no sample data.
  assign unused_status_bits = ^data_i[3:0];

  assign take     = ready_i & enable_i;
  assign done     = take & (cnt == CNT_MAX);
  assign sum      = acc + ACC_W'(data_i[15:4]);
  assign mean_new = ADC_BITS'(sum >> LOG2_PROM);

  assign wr   = (state == PEND) & ~fifo_full_i;
  assign drop = (state == PEND) & done & fifo_full_i;

  assign fifo_wr_en_o = wr;
  assign busy_o       = (state == ACUM) || (state == PEND);

  always_ff @(posedge clk_78MHz_i or negedge reset_i) begin
    if (!reset_i) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      seq        <= '0;
      fifo_din_o <= '0;
    end else begin
      if (!enable_i) begin
        acc <= '0;
        cnt <= '0;
      end else if (take) begin
        if (done) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + CNT_W'(1);
        end
      end

      if (wr) begin
        seq <= seq + SEQ_BITS'(1);
      end

      case (state)
        IDLE, ACUM: begin
          if (done) begin
            state      <= PEND;
            fifo_din_o <= {seq, mean_new};
          end else if (enable_i) begin
            state <= ACUM;
          end else begin
            state <= IDLE;
          end
        end
        PEND: begin
          // A block finishing while the old word leaves is reloaded with the next seq.
          if (done && wr) begin
            fifo_din_o <= {seq + SEQ_BITS'(1), mean_new};
          end else if (wr) begin
            state <= enable_i ? ACUM : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  contador_sat #(
    .WIDTH(8)
  ) u_overflow_cnt (
    .clk   (clk_78MHz_i),
    .rst_n (reset_i),
    .inc   (drop),
    .count (overflow_cnt_o)
  );

endmodule

// File: tb/tb_adc_promedio_fifo.sv
// tb/tb_adc_promedio_fifo.sv - directed bench for adc_promedio_fifo
module tb_adc_promedio_fifo;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        enable_i, ready_i, fifo_full_i;
  logic [15:0] data_i;
  logic        fifo_wr_en_o, busy_o;
  logic [15:0] fifo_din_o;
  logic [7:0]  overflow_cnt_o;

  logic        enable0, ready0, full0;
  logic [15:0] data0;
  logic        wr_en0, busy0;
  logic [15:0] din0;
  logic [7:0]  ovf0;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] wq[$];

  always #6 clk = ~clk;

  adc_promedio_fifo #(.LOG2_PROM(2)) dut (
    .clk_78MHz_i    (clk),
    .reset_i        (reset_i),
    .enable_i       (enable_i),
    .data_i         (data_i),
    .ready_i        (ready_i),
    .fifo_full_i    (fifo_full_i),
    .fifo_wr_en_o   (fifo_wr_en_o),
    .fifo_din_o     (fifo_din_o),
    .overflow_cnt_o (overflow_cnt_o),
    .busy_o         (busy_o)
  );

  adc_promedio_fifo #(.LOG2_PROM(0)) dut0 (
    .clk_78MHz_i    (clk),
    .reset_i        (reset_i),
    .enable_i       (enable0),
    .data_i         (data0),
    .ready_i        (ready0),
    .fifo_full_i    (full0),
    .fifo_wr_en_o   (wr_en0),
    .fifo_din_o     (din0),
    .overflow_cnt_o (ovf0),
    .busy_o         (busy0)
  );

  always @(posedge clk) begin
    if (fifo_wr_en_o) wq.push_back(fifo_din_o);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    data_i  = d;
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    #1;
    tick();
    reset_i = 1'b1;
    wq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; enable_i = 1'b0; ready_i = 1'b0; fifo_full_i = 1'b0; data_i = '0;
    enable0 = 1'b0; ready0 = 1'b0; full0 = 1'b0; data0 = '0;
    tick();

    // Asynchronous reset: outputs clear before any clock edge
    reset_i = 1'b0;
    #1;
    check("rst_wr_en", fifo_wr_en_o, 0);
    check("rst_din", fifo_din_o, 16'h0000);
    check("rst_ovf", overflow_cnt_o, 0);
    check("rst_busy", busy_o, 0);
    tick();
    reset_i = 1'b1;
    wq.delete();

    // Basic block average with one-cycle latency
    enable_i = 1'b1;
    tick();
    check("busy_acum", busy_o, 1);
    send(16'h1000); send(16'h2000); send(16'h3000);
    check("no_wr_early", fifo_wr_en_o, 0);
    send(16'h4000);
    check("wr_latency", fifo_wr_en_o, 1);
    check("din_0280", fifo_din_o, 16'h0280);
    tick();
    check("wr_one_cycle", fifo_wr_en_o, 0);
    check("one_word", wq.size(), 1);

    // ready ignored while disabled, then seq=1 on next word
    wq.delete();
    enable_i = 1'b0;
    tick();
    check("busy_idle", busy_o, 0);
    send(16'hFFF0); send(16'hFFF0);
    enable_i = 1'b1;
    send(16'h0100); send(16'h0200); send(16'h0300); send(16'h0400);
    tick();
    check("dis_count", wq.size(), 1);
    if (wq.size() > 0) check("dis_word", wq[0], 16'h1028);

    // Backpressure: second block dropped, first word kept
    do_reset();
    enable_i = 1'b1; fifo_full_i = 1'b1;
    send(16'h1000); send(16'h2000); send(16'h3000); send(16'h4000);
    for (int k = 0; k < 4; k++) send(16'h0010);
    check("full_no_wr", fifo_wr_en_o, 0);
    check("full_ovf1", overflow_cnt_o, 1);
    check("full_kept", fifo_din_o, 16'h0280);
    fifo_full_i = 1'b0;
    #1;
    check("release_wr", fifo_wr_en_o, 1);
    tick();
    check("release_cnt", wq.size(), 1);
    if (wq.size() > 0) check("release_word", wq[0], 16'h0280);

    // Overflow counter saturation
    do_reset();
    enable_i = 1'b1; fifo_full_i = 1'b1;
    for (int b = 1; b <= 300; b++) begin
      for (int k = 0; k < 4; k++) send(16'h0000);
      if (b == 255) check("ovf_254", overflow_cnt_o, 254);
      if (b == 256) check("ovf_255", overflow_cnt_o, 255);
    end
    check("ovf_sat", overflow_cnt_o, 255);
    check("ovf_no_wr", wq.size(), 0);
    fifo_full_i = 1'b0;
    tick();

    // Sequence wrap over 17 words
    do_reset();
    enable_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      for (int k = 0; k < 4; k++) send(16'((i * 16 + 5) << 4));
    end
    tick(); tick();
    check("seq_count", wq.size(), 17);
    for (int i = 0; i < 17 && i < wq.size(); i++) begin
      check($sformatf("seq_word%0d", i), wq[i], ((i % 16) << 12) | (i * 16 + 5));
    end

    // Reset mid-block discards the partial sum
    do_reset();
    enable_i = 1'b1;
    send(16'h1000); send(16'h2000);
    reset_i = 1'b0;
    #1;
    check("midrst_wr", fifo_wr_en_o, 0);
    check("midrst_busy", busy_o, 0);
    tick();
    reset_i = 1'b1;
    for (int k = 0; k < 4; k++) send(16'h0010);
    tick();
    check("midrst_cnt", wq.size(), 1);
    if (wq.size() > 0) check("midrst_word", wq[0], 16'h0001);

    // LOG2_PROM=0: one word per sample, every cycle
    enable0 = 1'b1; ready0 = 1'b1; data0 = 16'hFFF0;
    check("p0_before", wr_en0, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("p0_wr%0d", k), wr_en0, 1);
      check($sformatf("p0_din%0d", k), din0, ((k - 1) << 12) | 16'h0FFF);
    end
    check("p0_ovf", ovf0, 0);
    ready0 = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adc_promedio_fifo.md
ADC_PROMEDIO_FIFO -- requirements
Module: adc_promedio_fifo

Interface
REQ-001: Parameter LOG2_PROM, default 2, log2 of samples averaged per output word; legal range 0..4.
REQ-002: clk_78MHz_i  input  1  single clock; every register in the block is clocked on its rising edge.
REQ-003: reset_i  input  1  asynchronous, active-low reset.
REQ-004: enable_i  input  1  high means accept samples; low means ignore samples.
REQ-005: data_i  input  16  XADC DRP status word; the sample is data_i[15:4].
REQ-006: ready_i  input  1  one-cycle strobe; data_i is valid in that cycle.
REQ-007: fifo_full_i  input  1  downstream FIFO full flag.
REQ-008: fifo_wr_en_o  output  1  FIFO write strobe.
REQ-009: fifo_din_o  output  16  FIFO write word, packed as {seq[3:0], mean[11:0]}.
REQ-010: overflow_cnt_o  output  8  saturating count of dropped averages.
REQ-011: busy_o  output  1  high while the state is ACUM or PEND.

Function
REQ-012: A sample SHALL be taken only in a cycle where ready_i=1 and enable_i=1; ready_i SHALL be ignored otherwise.
REQ-013: The accumulator SHALL be 12+LOG2_PROM bits wide and SHALL never overflow.
REQ-014: The sample counter SHALL count 0..2^LOG2_PROM-1 and wrap to 0.
REQ-015: On the sample that makes the counter reach its terminal count, mean = (acc + sample) >> LOG2_PROM, truncated; the block SHALL register mean and clear acc to 0 in the same edge.
REQ-016: FSM states SHALL be IDLE, ACUM and PEND.
REQ-017: IDLE -> ACUM when enable_i=1.
REQ-018: ACUM -> PEND on block completion (REQ-015).
REQ-019: PEND -> ACUM when a write occurs and no new block completes in that cycle.
REQ-020: ACUM -> IDLE when enable_i=0.
REQ-021: PEND -> IDLE when enable_i=0 and the pending word has been written.
REQ-022: fifo_wr_en_o SHALL equal (state==PEND) AND NOT fifo_full_i, combinationally; fifo_wr_en_o is never asserted while fifo_full_i=1.
REQ-023: fifo_din_o SHALL be registered and stable for the whole time the state is PEND.
REQ-024: Latency: a completing ready_i in cycle t gives fifo_wr_en_o=1 in cycle t+1 when the FIFO is not full.
REQ-025: If a block completes in PEND in the same cycle as a write, the new mean SHALL be loaded and the state SHALL remain PEND; no word is dropped.
REQ-026: If a block completes in PEND with no write that cycle, the new mean SHALL be discarded, the old word kept, and overflow_cnt_o incremented, saturating at 255.
REQ-027: seq SHALL increment on each accepted write (fifo_wr_en_o=1) and wrap from 15 to 0.
REQ-028: While enable_i=0, acc and the sample counter SHALL be held at 0; a word already pending SHALL still be written.
REQ-029: With LOG2_PROM=0, every accepted sample SHALL produce one word, with mean = data_i[15:4].

Reset
REQ-030: With reset_i=0, asynchronously: state=IDLE, acc=0, sample counter=0, seq=0, mean=0, overflow_cnt_o=0, fifo_din_o=0, fifo_wr_en_o=0, busy_o=0.
REQ-031: Reset in the middle of a block or during PEND SHALL discard the partial sum and the pending word without any write; the next block SHALL start from sample 0.

Structure
REQ-032: A shared package adc_pkg SHALL hold the ADC_BITS=12 constant, the SEQ_BITS=4 constant and the FSM state encoding; the ADC wrapper and the FIFO stage use the same package.
REQ-033: One sub-module, contador_sat (parameterised width, saturating increment), SHALL implement overflow_cnt_o.

Verification
REQ-034: LOG2_PROM=2, enable_i=1, samples 0x1000, 0x2000, 0x3000, 0x4000, fifo_full_i=0 -> one cycle of fifo_wr_en_o=1, one cycle after the fourth ready_i, with fifo_din_o=0x0280.
REQ-035: Same stimulus with fifo_full_i=1 held through two full blocks -> no write, overflow_cnt_o=1; release full -> first word written with seq=0.
REQ-036: fifo_full_i=1 held for 300 dropped blocks -> overflow_cnt_o=255, stays 255.
REQ-037: 17 blocks with no backpressure -> seq field runs 0..15 then 0 on the 17th word.
REQ-038: Reset asserted after 2 of 4 samples, then 4 samples of 0x0010 -> single word 0x0001 (first seq=0); the partial sum does not contribute.
REQ-039: LOG2_PROM=0, ready_i pulsed every cycle with data_i=0xFFF0 -> fifo_wr_en_o=1 each cycle from t+1, mean=0xFFF, no overflow.
